// File: rtl/snn_stream_driver.sv
// Frame buffer and streamer for the SNN input port: holds one frame, plays it out as
// IMG_LEN contiguous beats, then waits (bounded by TIMEOUT) for the core's response.
module snn_stream_driver #(
  parameter int DW      = 8,
  parameter int IMG_LEN = 72,
  parameter int KER_LEN = 9,
  parameter int WT_LEN  = 4,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [1:0]    cfg_sel,
  input  logic [6:0]    cfg_addr,
  input  logic [DW-1:0] cfg_data,
  input  logic          start,
  output logic          snn_in_valid,
  output logic [DW-1:0] snn_img,
  output logic [DW-1:0] snn_ker,
  output logic [DW-1:0] snn_weight,
  input  logic          snn_out_valid,
  input  logic [9:0]    snn_out_data,
  output logic          busy,
  output logic          done,
  output logic          timeout_err,
  output logic [9:0]    result
);

  localparam int AW = 7;
  localparam int KW = $clog2(KER_LEN);
  localparam int WW = $clog2(WT_LEN);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [AW-1:0] IMG_N   = AW'(IMG_LEN);
  localparam logic [AW-1:0] KER_N   = AW'(KER_LEN);
  localparam logic [AW-1:0] WT_N    = AW'(WT_LEN);
  localparam logic [AW-1:0] LAST    = AW'(IMG_LEN - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

  state_t        state;
  logic [AW-1:0] idx;
  logic [AW-1:0] nxt_idx;
  logic [CW-1:0] cnt;

  logic [DW-1:0] img_buf [IMG_LEN];
  logic [DW-1:0] ker_buf [KER_LEN];
  logic [DW-1:0] wt_buf  [WT_LEN];

  logic          wr_ok, wr_img, wr_ker, wr_wt;
  logic [DW-1:0] nxt_img, nxt_ker, nxt_wt;

  assign wr_ok  = cfg_we && (state == IDLE);
  assign wr_img = wr_ok && (cfg_sel == 2'd0) && (cfg_addr < IMG_N);
  assign wr_ker = wr_ok && (cfg_sel == 2'd1) && (cfg_addr < KER_N);
  assign wr_wt  = wr_ok && (cfg_sel == 2'd2) && (cfg_addr < WT_N);

  assign nxt_idx = (state == SEND && idx != LAST) ? idx + AW'(1) : '0;

  always_ff @(posedge clk) begin
    if (wr_img) img_buf[cfg_addr] <= cfg_data;
    if (wr_ker) ker_buf[cfg_addr[KW-1:0]] <= cfg_data;
    if (wr_wt)  wt_buf[cfg_addr[WW-1:0]] <= cfg_data;
  end

  // A write in the same IDLE cycle as start must reach beat 0, so forward it past the array.
  always_comb begin
    nxt_img = img_buf[nxt_idx];
    if (wr_img && cfg_addr == nxt_idx) nxt_img = cfg_data;
    nxt_ker = '0;
    if (nxt_idx < KER_N) begin
      nxt_ker = ker_buf[nxt_idx[KW-1:0]];
      if (wr_ker && cfg_addr == nxt_idx) nxt_ker = cfg_data;
    end
    nxt_wt = '0;
    if (nxt_idx < WT_N) begin
      nxt_wt = wt_buf[nxt_idx[WW-1:0]];
      if (wr_wt && cfg_addr == nxt_idx) nxt_wt = cfg_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      cnt          <= '0;
      snn_in_valid <= 1'b0;
      snn_img      <= '0;
      snn_ker      <= '0;
      snn_weight   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      timeout_err  <= 1'b0;
      result       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state        <= SEND;
            idx          <= '0;
            busy         <= 1'b1;
            result       <= '0;
            timeout_err  <= 1'b0;
            snn_in_valid <= 1'b1;
            snn_img      <= nxt_img;
            snn_ker      <= nxt_ker;
            snn_weight   <= nxt_wt;
          end
        end
        SEND: begin
          if (idx == LAST) begin
            state        <= WAIT;
            cnt          <= '0;
            snn_in_valid <= 1'b0;
            snn_img      <= '0;
            snn_ker      <= '0;
            snn_weight   <= '0;
          end else begin
            idx        <= nxt_idx;
            snn_img    <= nxt_img;
            snn_ker    <= nxt_ker;
            snn_weight <= nxt_wt;
          end
        end
        WAIT: begin
          // A response arriving on the final timeout cycle still counts as a response.
          if (snn_out_valid) begin
            result      <= snn_out_data;
            timeout_err <= 1'b0;
            done        <= 1'b1;
            state       <= DONE;
          end else if (cnt == CNT_MAX) begin
            timeout_err <= 1'b1;
            done        <= 1'b1;
            state       <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
